div_seq: RTL

//  Multi-cycle restoring divider and its sequencer. The EX stage issues DIV/DIVU to it;
//  it produces {remainder, quotient} for the HI/LO write path, one quotient bit per cycle.
//  EX holds its stall request while a division is in flight.

---
 rtl/div_seq_pkg.sv | 14 +
 rtl/div_seq.sv | 103 ++++++++++
 2 files changed

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: state encodings and shared constants for the sequential divider.
package div_seq_pkg;
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;
    localparam logic        DIV_START            = 1'b1;
    localparam logic        DIV_STOP             = 1'b0;
    localparam logic        DIV_RESULT_READY     = 1'b1;
    localparam logic        DIV_RESULT_NOT_READY = 1'b0;
    localparam logic [31:0] ZERO_WORD            = 32'h0;
endpackage

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider producing {remainder, quotient}, one quotient bit per cycle.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);
    div_state_t         r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem, r_quo, r_dvs;
    logic               r_sgn, r_neg1, r_neg2, r_ready;
    logic [2*WIDTH-1:0] r_result;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_abs1, w_abs2, w_quo_fix, w_rem_fix;
    logic               w_accept, w_zero, w_last, w_hold;

    // r_quo starts as |dividend| and is shifted left each step, so its MSB feeds the remainder
    // while quotient bits fill in from the bottom.
    always_comb begin
        w_accept  = start_i == DIV_START && !annul_i;
        w_zero    = opdata2_i == WIDTH'(ZERO_WORD);
        w_hold    = start_i == DIV_START && !annul_i;
        w_last    = r_cnt == CNT_W'(WIDTH - 1);
        w_abs1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        w_abs2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        w_diff    = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
        w_quo_fix = (r_sgn && (r_neg1 ^ r_neg2)) ? -r_quo : r_quo;
        w_rem_fix = (r_sgn && r_neg1) ? -r_rem : r_rem;
    end

    always_comb begin
        w_next = r_state;
        busy_o = r_state == DIV_BY_ZERO || r_state == DIV_ON;
        case (r_state)
            DIV_FREE:    w_next = w_accept ? (w_zero ? DIV_BY_ZERO : DIV_ON) : DIV_FREE;
            DIV_BY_ZERO: w_next = annul_i ? DIV_FREE : DIV_END;
            DIV_ON:      w_next = annul_i ? DIV_FREE : (w_last ? DIV_END : DIV_ON);
            DIV_END:     w_next = (annul_i || start_i == DIV_STOP) ? DIV_FREE : DIV_END;
            default:     w_next = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= DIV_FREE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_sgn    <= 1'b0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_ready  <= DIV_RESULT_NOT_READY;
            r_result <= '0;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    r_ready  <= DIV_RESULT_NOT_READY;
                    r_result <= '0;
                    if (w_accept) begin
                        r_cnt  <= '0;
                        r_rem  <= '0;
                        r_quo  <= w_zero ? '0 : w_abs1;
                        r_dvs  <= w_abs2;
                        r_sgn  <= signed_div_i;
                        r_neg1 <= signed_div_i & opdata1_i[WIDTH-1];
                        r_neg2 <= signed_div_i & opdata2_i[WIDTH-1];
                    end
                end
                DIV_ON: begin
                    if (!annul_i) begin
                        r_rem <= w_diff[WIDTH] ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_diff[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], !w_diff[WIDTH]};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DIV_END: begin
                    r_ready  <= w_hold ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
                    r_result <= w_hold ? {w_rem_fix, w_quo_fix} : '0;
                end
                default: ;
            endcase
        end
    end

    assign ready_o  = r_ready;
    assign result_o = r_result;
endmodule
